controlador_memoria_dados: RTL

- Initiator side of the data-memory port: the CPU issues LOAD/STORE/COPY requests, and this block turns them into Endereco/DadoEscrito/EscMem/LerMem cycles, then captures DadoLido.
- The attached data memory writes on posedge when EscMem=1 and drives DadoLido on negedge when LerMem=1.
- The block sits between the datapath or a future DMA master and the data memory, so only one master drives the memory port.

---
 rtl/controlador_memoria_dados.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/controlador_memoria_dados.sv
// Data-memory port initiator: turns CPU LOAD/STORE/COPY requests into
// Endereco/DadoEscrito/EscMem/LerMem cycles and returns a one-cycle response.
module controlador_memoria_dados #(
    parameter int LARGURA_DADO     = 8,
    parameter int LARGURA_END      = 8,
    parameter bit COPIA_HABILITADA = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    ReqValido,
    output logic                    ReqPronto,
    input  logic [1:0]              ReqOp,
    input  logic [LARGURA_END-1:0]  ReqEndereco,
    input  logic [LARGURA_END-1:0]  ReqDestino,
    input  logic [LARGURA_DADO-1:0] ReqDado,
    input  logic [7:0]              ReqTamanho,
    output logic                    RespValido,
    output logic [LARGURA_DADO-1:0] RespDado,
    output logic                    RespErro,
    output logic                    Ocupado,
    output logic [LARGURA_END-1:0]  Endereco,
    output logic [LARGURA_DADO-1:0] DadoEscrito,
    output logic                    EscMem,
    output logic                    LerMem,
    input  logic [LARGURA_DADO-1:0] DadoLido
);

    typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, RESPOSTA} estado_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    estado_t                 estado_reg, estado_next;
    logic                    pronto_reg, pronto_next;
    logic                    resp_valido_reg, resp_valido_next;
    logic [LARGURA_DADO-1:0] resp_dado_reg, resp_dado_next;
    logic                    resp_erro_reg, resp_erro_next;
    logic [LARGURA_END-1:0]  endereco_reg, endereco_next;
    logic [LARGURA_DADO-1:0] dado_escrito_reg, dado_escrito_next;
    logic                    esc_mem_reg, esc_mem_next;
    logic                    ler_mem_reg, ler_mem_next;
    logic                    copia_reg, copia_next;
    logic [LARGURA_END-1:0]  origem_reg, origem_next;
    logic [LARGURA_END-1:0]  destino_reg, destino_next;
    logic [7:0]              restante_reg, restante_next;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_reg       <= OCIOSO;
            pronto_reg       <= 1'b0;
            resp_valido_reg  <= 1'b0;
            resp_dado_reg    <= '0;
            resp_erro_reg    <= 1'b0;
            endereco_reg     <= '0;
            dado_escrito_reg <= '0;
            esc_mem_reg      <= 1'b0;
            ler_mem_reg      <= 1'b0;
            copia_reg        <= 1'b0;
            origem_reg       <= '0;
            destino_reg      <= '0;
            restante_reg     <= '0;
        end else begin
            estado_reg       <= estado_next;
            pronto_reg       <= pronto_next;
            resp_valido_reg  <= resp_valido_next;
            resp_dado_reg    <= resp_dado_next;
            resp_erro_reg    <= resp_erro_next;
            endereco_reg     <= endereco_next;
            dado_escrito_reg <= dado_escrito_next;
            esc_mem_reg      <= esc_mem_next;
            ler_mem_reg      <= ler_mem_next;
            copia_reg        <= copia_next;
            origem_reg       <= origem_next;
            destino_reg      <= destino_next;
            restante_reg     <= restante_next;
        end
    end

    always_comb begin
        estado_next       = estado_reg;
        resp_valido_next  = 1'b0;
        resp_dado_next    = resp_dado_reg;
        resp_erro_next    = resp_erro_reg;
        endereco_next     = endereco_reg;
        dado_escrito_next = dado_escrito_reg;
        esc_mem_next      = 1'b0;
        ler_mem_next      = 1'b0;
        copia_next        = copia_reg;
        origem_next       = origem_reg;
        destino_next      = destino_reg;
        restante_next     = restante_reg;

        case (estado_reg)
            OCIOSO: begin
                if (ReqValido && pronto_reg) begin
                    case (ReqOp)
                        OP_LOAD: begin
                            estado_next   = LEITURA;
                            ler_mem_next  = 1'b1;
                            endereco_next = ReqEndereco;
                            copia_next    = 1'b0;
                        end
                        OP_STORE: begin
                            estado_next       = ESCRITA;
                            esc_mem_next      = 1'b1;
                            endereco_next     = ReqEndereco;
                            dado_escrito_next = ReqDado;
                            copia_next        = 1'b0;
                        end
                        OP_COPY: begin
                            if (!COPIA_HABILITADA || ReqTamanho == 8'd0) begin
                                estado_next      = RESPOSTA;
                                resp_valido_next = 1'b1;
                                resp_erro_next   = !COPIA_HABILITADA;
                                resp_dado_next   = '0;
                            end else begin
                                estado_next   = LEITURA;
                                ler_mem_next  = 1'b1;
                                endereco_next = ReqEndereco;
                                origem_next   = ReqEndereco + 1'b1;
                                destino_next  = ReqDestino;
                                restante_next = ReqTamanho - 8'd1;
                                copia_next    = 1'b1;
                            end
                        end
                        default: begin
                            estado_next      = RESPOSTA;
                            resp_valido_next = 1'b1;
                            resp_erro_next   = 1'b1;
                            resp_dado_next   = '0;
                        end
                    endcase
                end
            end
            LEITURA: begin
                if (copia_reg) begin
                    // The word read this cycle goes straight out as write data.
                    estado_next       = ESCRITA;
                    esc_mem_next      = 1'b1;
                    endereco_next     = destino_reg;
                    dado_escrito_next = DadoLido;
                    destino_next      = destino_reg + 1'b1;
                end else begin
                    estado_next      = RESPOSTA;
                    resp_valido_next = 1'b1;
                    resp_erro_next   = 1'b0;
                    resp_dado_next   = DadoLido;
                end
            end
            ESCRITA: begin
                if (copia_reg && restante_reg != 8'd0) begin
                    estado_next   = LEITURA;
                    ler_mem_next  = 1'b1;
                    endereco_next = origem_reg;
                    origem_next   = origem_reg + 1'b1;
                    restante_next = restante_reg - 8'd1;
                end else begin
                    estado_next      = RESPOSTA;
                    resp_valido_next = 1'b1;
                    resp_erro_next   = 1'b0;
                    resp_dado_next   = dado_escrito_reg;
                end
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase

        pronto_next = (estado_next == OCIOSO);
    end

    assign ReqPronto   = pronto_reg;
    assign RespValido  = resp_valido_reg;
    assign RespDado    = resp_dado_reg;
    assign RespErro    = resp_erro_reg;
    assign Ocupado     = (estado_reg != OCIOSO);
    assign Endereco    = endereco_reg;
    assign DadoEscrito = dado_escrito_reg;
    assign EscMem      = esc_mem_reg;
    assign LerMem      = ler_mem_reg;

endmodule
